// File: rtl/curtain_ctrl_if.sv
// Signal bundle between the ADC/operator side and the curtain motion controller.
// The master drives samples and switches; the slave drives the coil bus and status.
interface curtain_ctrl_if;
  logic [7:0]  adc_data;
  logic        adc_valid;
  logic [3:0]  sw;
  logic [3:0]  bus;
  logic [11:0] pos;
  logic        busy;
  logic        at_open;
  logic        at_closed;

  modport master (
    output adc_data, adc_valid, sw,
    input  bus, pos, busy, at_open, at_closed
  );

  modport slave (
    input  adc_data, adc_valid, sw,
    output bus, pos, busy, at_open, at_closed
  );
endinterface

// File: rtl/curtain_ctrl.sv
// Light-driven curtain motion controller: debounces ADC light classes, runs a
// 4-phase stepper between the open (0) and closed (POS_MAX) limits.
module curtain_ctrl #(
  parameter int STEP_DIV = 50000,
  parameter int POS_MAX  = 2048,
  parameter int TH_LO    = 64,
  parameter int TH_HI    = 192,
  parameter int SETTLE   = 4
) (
  input  logic           clk,
  input  logic           rst,
  curtain_ctrl_if.slave  cif
);

  typedef enum logic [1:0] {IDLE, OPEN_RUN, CLOSE_RUN} state_t;
  typedef enum logic [1:0] {CL_MID, CL_DARK, CL_BRIGHT} class_t;

  localparam int               DIV_W   = $clog2(STEP_DIV);
  localparam int               CNT_W   = $clog2(SETTLE + 1);
  localparam logic [11:0]      POS_TOP = 12'(POS_MAX);
  localparam logic [DIV_W-1:0] DIV_TOP = DIV_W'(STEP_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(SETTLE);
  localparam logic [7:0]       LO_B    = 8'(TH_LO);
  localparam logic [7:0]       HI_B    = 8'(TH_HI);

  state_t           state;
  class_t           last_class;
  class_t           sample_class;
  logic [CNT_W-1:0] settle_cnt;
  logic [1:0]       phase;
  logic [DIV_W-1:0] div;
  logic             run_manual;
  logic [11:0]      pos_q;
  logic [3:0]       bus_q;

  logic cmd_open, cmd_close, run_close, keep_cmd, opposite_cmd, at_limit;
  logic stop_run, tick, settled;

  function automatic logic [3:0] phase_bus(input logic [1:0] p);
    return 4'b0001 << p;
  endfunction

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    sample_class = CL_MID;
    if (cif.adc_data > HI_B)      sample_class = CL_BRIGHT;
    else if (cif.adc_data < LO_B) sample_class = CL_DARK;
  end

  // Commands come from registered class state and the live switches only.
  assign settled   = (settle_cnt == CNT_TOP);
  assign cmd_close = cif.sw[0] ? (cif.sw[2] & ~cif.sw[1])
                               : (settled && last_class == CL_BRIGHT);
  assign cmd_open  = cif.sw[0] ? (cif.sw[1] & ~cif.sw[2])
                               : (settled && last_class == CL_DARK);

  assign run_close    = (state == CLOSE_RUN);
  assign keep_cmd     = run_close ? cmd_close : cmd_open;
  assign opposite_cmd = run_close ? cmd_open  : cmd_close;
  assign at_limit     = run_close ? (pos_q == POS_TOP) : (pos_q == 12'd0);
  assign stop_run     = at_limit | cif.sw[3] | (cif.sw[0] != run_manual)
                      | (cif.sw[0] & ~keep_cmd) | opposite_cmd;
  assign tick         = (div == DIV_TOP);

  // NOTE: all state is updated with non-blocking assignments so every branch
  // reads the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_class <= CL_MID;
      settle_cnt <= '0;
      phase      <= 2'd0;
      div        <= '0;
      run_manual <= 1'b0;
      pos_q      <= 12'd0;
      bus_q      <= 4'b0000;
    end else begin
      if (cif.adc_valid) begin
        if (sample_class == last_class) begin
          if (!settled) settle_cnt <= settle_cnt + CNT_W'(1);
        end else begin
          last_class <= sample_class;
          settle_cnt <= CNT_W'(1);
        end
      end

      case (state)
        IDLE: begin
          bus_q <= 4'b0000;
          div   <= '0;
          if (!cif.sw[3] && cmd_close && pos_q != POS_TOP) begin
            state      <= CLOSE_RUN;
            run_manual <= cif.sw[0];
            bus_q      <= phase_bus(phase);
          end else if (!cif.sw[3] && cmd_open && pos_q != 12'd0) begin
            state      <= OPEN_RUN;
            run_manual <= cif.sw[0];
            bus_q      <= phase_bus(phase);
          end
        end
        default: begin
          // An abort wins over a coincident tick, so a stop freezes pos.
          if (stop_run) begin
            state <= IDLE;
            bus_q <= 4'b0000;
          end else if (tick) begin
            div <= '0;
            if (run_close) begin
              phase <= phase + 2'd1;
              pos_q <= pos_q + 12'd1;
              bus_q <= phase_bus(phase + 2'd1);
            end else begin
              phase <= phase - 2'd1;
              pos_q <= pos_q - 12'd1;
              bus_q <= phase_bus(phase - 2'd1);
            end
          end else begin
            div <= div + DIV_W'(1);
          end
        end
      endcase
    end
  end

  assign cif.bus       = bus_q;
  assign cif.pos       = pos_q;
  assign cif.busy      = (state != IDLE);
  assign cif.at_open   = (pos_q == 12'd0);
  assign cif.at_closed = (pos_q == POS_TOP);

endmodule

// File: tb/tb_curtain_ctrl.sv
// Bench for curtain_ctrl: directed scenarios plus random traffic, with a
// cycle-level reference model feeding a scoreboard queue read by a monitor.
module tb_curtain_ctrl;

  localparam int STEP_DIV = 4;
  localparam int POS_MAX  = 8;
  localparam int TH_LO    = 64;
  localparam int TH_HI    = 192;
  localparam int SETTLE   = 3;

  typedef struct packed {
    logic [3:0]  bus;
    logic [11:0] pos;
    logic        busy;
    logic        at_open;
    logic        at_closed;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  obs_t exp_q[$];

  curtain_ctrl_if cif();

  curtain_ctrl #(
    .STEP_DIV (STEP_DIV),
    .POS_MAX  (POS_MAX),
    .TH_LO    (TH_LO),
    .TH_HI    (TH_HI),
    .SETTLE   (SETTLE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .cif (cif)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // 0 = MID, 1 = DARK, 2 = BRIGHT
  function automatic int classify(input int v);
    if (v > TH_HI) return 2;
    if (v < TH_LO) return 1;
    return 0;
  endfunction

  // Reference model: direction (+1 closing, -1 opening, 0 stopped), position
  // and cycles spent running; the coil is simply pos mod 4 while moving.
  initial begin : ref_model
    int   m_pos, m_dir, m_run, m_last, m_cnt, m_goal, c;
    logic m_man, want_close, want_open, keep, opp;
    logic [3:0] s;
    obs_t e;
    m_pos = 0; m_dir = 0; m_run = 0; m_last = 0; m_cnt = 0; m_man = 1'b0;
    forever begin
      @(posedge clk);
      s = cif.sw;
      if (rst) begin
        m_pos = 0; m_dir = 0; m_run = 0; m_last = 0; m_cnt = 0;
      end else begin
        want_close = s[0] ? (s[2] && !s[1]) : (m_last == 2 && m_cnt == SETTLE);
        want_open  = s[0] ? (s[1] && !s[2]) : (m_last == 1 && m_cnt == SETTLE);
        if (m_dir == 0) begin
          if (!s[3] && want_close && m_pos < POS_MAX) begin
            m_dir = 1; m_run = 0; m_man = s[0];
          end else if (!s[3] && want_open && m_pos > 0) begin
            m_dir = -1; m_run = 0; m_man = s[0];
          end
        end else begin
          m_goal = (m_dir > 0) ? POS_MAX : 0;
          keep   = (m_dir > 0) ? want_close : want_open;
          opp    = (m_dir > 0) ? want_open : want_close;
          if (m_pos == m_goal || s[3] || s[0] != m_man || (s[0] && !keep) || opp) begin
            m_dir = 0;
          end else begin
            m_run++;
            if (m_run % STEP_DIV == 0) m_pos += m_dir;
          end
        end
        if (cif.adc_valid) begin
          c = classify(int'(cif.adc_data));
          if (c == m_last) m_cnt = (m_cnt < SETTLE) ? m_cnt + 1 : SETTLE;
          else begin m_last = c; m_cnt = 1; end
        end
      end
      e.bus       = (m_dir != 0) ? 4'(1 << (m_pos % 4)) : 4'b0000;
      e.pos       = 12'(m_pos);
      e.busy      = (m_dir != 0);
      e.at_open   = (m_pos == 0);
      e.at_closed = (m_pos == POS_MAX);
      exp_q.push_back(e);
    end
  end

  initial begin : monitor
    obs_t e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{cif.bus, cif.pos, cif.busy, cif.at_open, cif.at_closed};
        n_checks++;
        if (a !== e) begin
          n_errors++;
          $display("FAIL scoreboard at %0t: got bus=%b pos=%0d busy=%b ao=%b ac=%b, expected bus=%b pos=%0d busy=%b ao=%b ac=%b",
                   $time, a.bus, a.pos, a.busy, a.at_open, a.at_closed,
                   e.bus, e.pos, e.busy, e.at_open, e.at_closed);
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sample(input logic [7:0] v);
    @(negedge clk);
    cif.adc_valid = 1'b1;
    cif.adc_data  = v;
    @(negedge clk);
    cif.adc_valid = 1'b0;
  endtask

  task automatic wait_pos(input string name, input int target, input int budget);
    int n = 0;
    while (cif.pos !== 12'(target) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(cif.pos), 32'(target));
  endtask

  initial begin : stimulus
    logic [11:0] p0;
    int r;
    rst = 1'b1;
    cif.sw = 4'b0000;
    cif.adc_valid = 1'b0;
    cif.adc_data = 8'd0;
    cycles(2);
    check("reset_bus", 32'(cif.bus), 32'h0);
    check("reset_pos", 32'(cif.pos), 32'd0);
    check("reset_busy", 32'(cif.busy), 32'd0);
    check("reset_at_open", 32'(cif.at_open), 32'd1);
    check("reset_at_closed", 32'(cif.at_closed), 32'd0);
    rst = 1'b0;

    // Settle break then auto close to the limit
    sample(8'd200); sample(8'd200); sample(8'd100); sample(8'd200); sample(8'd200);
    cycles(6);
    check("settle_break_hold", 32'(cif.busy), 32'd0);
    sample(8'd200);
    cycles(1);
    check("auto_close_start", 32'(cif.busy), 32'd1);
    check("auto_close_first_coil", 32'(cif.bus), 32'b0001);
    cycles(4);
    check("first_tick_pos", 32'(cif.pos), 32'd1);
    check("first_tick_bus", 32'(cif.bus), 32'b0010);
    wait_pos("auto_close_reach_limit", POS_MAX, 100);
    check("limit_tick_bus", 32'(cif.bus), 32'b0001);
    cycles(1);
    check("limit_idle_busy", 32'(cif.busy), 32'd0);
    check("limit_idle_bus", 32'(cif.bus), 32'h0);
    check("limit_at_closed", 32'(cif.at_closed), 32'd1);

    // Exactly TH_LO is MID and cannot start an open
    repeat (4) sample(8'd64);
    cycles(3);
    check("th_lo_is_mid", 32'(cif.busy), 32'd0);

    // Manual open, release at pos 5, both buttons does nothing
    cif.sw = 4'b0011;
    wait_pos("manual_open_to_5", 5, 100);
    cif.sw = 4'b0001;
    cycles(2);
    check("release_busy", 32'(cif.busy), 32'd0);
    check("release_bus", 32'(cif.bus), 32'h0);
    check("release_pos", 32'(cif.pos), 32'd5);
    cif.sw = 4'b0111;
    cycles(12);
    check("both_buttons_idle", 32'(cif.busy), 32'd0);
    check("both_buttons_pos", 32'(cif.pos), 32'd5);

    // Stop pulse during close, then reversal
    cif.sw = 4'b0101;
    cycles(6);
    cif.sw = 4'b1101;
    p0 = cif.pos;
    cycles(1);
    check("stop_idle", 32'(cif.busy), 32'd0);
    check("stop_pos_frozen", 32'(cif.pos), 32'(p0));
    cif.sw = 4'b0101;
    cycles(1);
    check("restart_after_stop", 32'(cif.busy), 32'd1);
    cycles(5);
    cif.sw = 4'b0011;
    cycles(1);
    check("reversal_idle_cycle", 32'(cif.busy), 32'd0);
    cycles(1);
    check("reversal_open_run", 32'(cif.busy), 32'd1);
    wait_pos("open_to_limit", 0, 100);
    cycles(1);
    check("open_limit_idle", 32'(cif.busy), 32'd0);
    check("open_limit_at_open", 32'(cif.at_open), 32'd1);

    // Exactly TH_HI is MID and cannot start a close
    cif.sw = 4'b0000;
    repeat (4) sample(8'd192);
    cycles(3);
    check("th_hi_is_mid", 32'(cif.busy), 32'd0);

    // Reset mid-run clears position and settle count
    repeat (3) sample(8'd230);
    wait_pos("close_to_3", 3, 100);
    rst = 1'b1;
    cycles(1);
    check("midrun_reset_pos", 32'(cif.pos), 32'd0);
    check("midrun_reset_bus", 32'(cif.bus), 32'h0);
    check("midrun_reset_busy", 32'(cif.busy), 32'd0);
    rst = 1'b0;
    sample(8'd230); sample(8'd230);
    cycles(4);
    check("settle_cleared_by_reset", 32'(cif.busy), 32'd0);
    sample(8'd230);
    cycles(1);
    check("settle_after_reset", 32'(cif.busy), 32'd1);

    // Random traffic, checked by the scoreboard every cycle
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      cif.adc_valid = ($urandom_range(0, 2) == 0);
      r = int'($urandom_range(0, 5));
      if (r < 2)       cif.adc_data = 8'($urandom_range(193, 255));
      else if (r < 4)  cif.adc_data = 8'($urandom_range(0, 63));
      else if (r == 4) cif.adc_data = 8'($urandom_range(0, 255));
      else             cif.adc_data = ($urandom_range(0, 1) == 0) ? 8'd64 : 8'd192;
      if ($urandom_range(0, 24) == 0)
        cif.sw = 4'($urandom_range(0, 15)) & (($urandom_range(0, 3) == 0) ? 4'hF : 4'h7);
      rst = ($urandom_range(0, 599) == 0);
    end
    rst = 1'b0;
    cif.adc_valid = 1'b0;
    cycles(3);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
